pq_rd_host: RTL and testbench

//  Host-side driver for the replace/dequeue priority-queue interface (pq_rd_if, host end).
//  - Accepts a command stream (PEEK/REPLACE/DEQ) on a valid/ready channel.
//  - Issues each command to the queue device, honouring di.busy.
//  - Returns the queue head removed (or observed) by each command on a valid/ready response channel.
//  - Sits between test/application logic and any pq_rd_if device; keeps busy-protocol handling in one place.

---
 rtl/pq_pkg.sv | 20 ++
 rtl/pq_rd_host_if.sv | 26 ++
 rtl/pq_rd_host.sv | 95 +++++++++
 tb/tb_pq_rd_host.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared key/value element type and sentinels for the replace/dequeue priority queue.
package pq_pkg;

  typedef struct packed {
    logic [15:0] key;
    logic [15:0] val;
  } kv_t;

  localparam logic [15:0] KEYINF    = 16'hFFFF;
  localparam logic [15:0] KEYNEGINF = 16'h0000;
  localparam logic [15:0] VAL0      = 16'h0000;

  typedef enum logic [1:0] {
    OP_PEEK    = 2'b00,
    OP_REPLACE = 2'b01,
    OP_DEQ     = 2'b10,
    OP_ILL     = 2'b11
  } pq_op_e;

endpackage

// File: rtl/pq_rd_host_if.sv
// Command and response channels between application logic and the pq_rd_host driver.
interface pq_rd_host_if;
  import pq_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  kv_t        cmd_kv;
  logic       rsp_valid;
  logic       rsp_ready;
  kv_t        rsp_kv;
  logic       rsp_empty;
  logic       rsp_full;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_kv, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_kv, rsp_empty, rsp_full, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_kv, rsp_ready,
    output cmd_ready, rsp_valid, rsp_kv, rsp_empty, rsp_full, rsp_err
  );

endinterface

// File: rtl/pq_rd_host.sv
// Host-side driver for a replace/dequeue priority queue: one pending command slot,
// busy-aware issue to the device, and a one-deep response register.
module pq_rd_host
  import pq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pq_rd_host_if.slave      cif,
  output kv_t              pq_kvi,
  output logic             pq_replace,
  output logic             pq_deq,
  input  kv_t              pq_kvo,
  input  logic             pq_busy,
  input  logic             pq_full,
  input  logic             pq_empty,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_stalls
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  logic       vld_p0;
  logic [1:0] op_p0;
  kv_t        kv_p0;

  logic       vld_p1;
  kv_t        kv_p1;
  logic       empty_p1;
  logic       full_p1;
  logic       err_p1;

  logic       slot_free;
  logic       issue;
  logic       accept;

  assign slot_free     = !vld_p1 || cif.rsp_ready;
  assign issue         = vld_p0 && !pq_busy && slot_free && !rst;
  assign cif.cmd_ready = !rst && (!vld_p0 || issue);
  assign accept        = cif.cmd_valid && cif.cmd_ready;

  // Stage p0: pending command, held stable on the device bus until it issues
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= cif.cmd_op;
      kv_p0 <= cif.cmd_kv;
    end
  end

  assign pq_kvi     = vld_p0 ? kv_p0 : '0;
  assign pq_replace = issue && (op_p0 == OP_REPLACE);
  assign pq_deq     = issue && (op_p0 == OP_DEQ);

  // Stage p1: response captured from the pre-operation head in the issue cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      kv_p1       <= '0;
      empty_p1    <= 1'b0;
      full_p1     <= 1'b0;
      err_p1      <= 1'b0;
      stat_ops    <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept)
        vld_p0 <= 1'b1;
      else if (issue)
        vld_p0 <= 1'b0;

      if (issue) begin
        vld_p1   <= 1'b1;
        kv_p1    <= pq_kvo;
        empty_p1 <= pq_empty;
        full_p1  <= pq_full;
        err_p1   <= (op_p0 == OP_ILL);
      end else if (cif.rsp_ready) begin
        vld_p1 <= 1'b0;
      end

      stat_ops    <= sat_inc(stat_ops, issue);
      stat_stalls <= sat_inc(stat_stalls, vld_p0 && pq_busy);
    end
  end

  assign cif.rsp_valid = vld_p1;
  assign cif.rsp_kv    = kv_p1;
  assign cif.rsp_empty = empty_p1;
  assign cif.rsp_full  = full_p1;
  assign cif.rsp_err   = err_p1;

endmodule

// File: tb/tb_pq_rd_host.sv
// Bench for pq_rd_host: sorted 8-entry queue device model plus an in-order response scoreboard.
module tb_pq_rd_host;
  import pq_pkg::*;

  localparam int CNT_W = 32;
  typedef kv_t [7:0] qv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pq_rd_host_if cif();

  kv_t              pq_kvi;
  kv_t              pq_kvo;
  logic             pq_replace, pq_deq, pq_busy, pq_full, pq_empty;
  logic [CNT_W-1:0] stat_ops, stat_stalls;

  pq_rd_host #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cif        (cif.slave),
    .pq_kvi     (pq_kvi),
    .pq_replace (pq_replace),
    .pq_deq     (pq_deq),
    .pq_kvo     (pq_kvo),
    .pq_busy    (pq_busy),
    .pq_full    (pq_full),
    .pq_empty   (pq_empty),
    .stat_ops   (stat_ops),
    .stat_stalls(stat_stalls)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic kv_t mk(input int key);
    kv_t r;
    r.key = 16'(key);
    r.val = (key == 16'hFFFF) ? VAL0 : 16'(key + 256);
    return r;
  endfunction

  function automatic qv_t mkq3(input int k0, input int k1, input int k2);
    qv_t r;
    for (int i = 0; i < 8; i++) r[i] = mk(16'hFFFF);
    r[0] = mk(k0);
    r[1] = mk(k1);
    r[2] = mk(k2);
    return r;
  endfunction

  function automatic qv_t q_deq(input qv_t q);
    qv_t r;
    for (int i = 0; i < 7; i++) r[i] = q[i+1];
    r[7] = mk(16'hFFFF);
    return r;
  endfunction

  function automatic qv_t q_rep(input qv_t q, input kv_t kv);
    qv_t r;
    kv_t t;
    r = q_deq(q);
    r[7] = kv;
    for (int i = 7; i > 0; i--) begin
      if (r[i].key < r[i-1].key) begin
        t = r[i]; r[i] = r[i-1]; r[i-1] = t;
      end
    end
    return r;
  endfunction

  // Device model: sorted array, head at index 0
  qv_t  dq, rq, dev_ld_v;
  logic dev_ld = 1'b0;
  int   nstrobe = 0;

  always @(posedge clk) begin
    if (dev_ld)          dq <= dev_ld_v;
    else if (pq_deq)     dq <= q_deq(dq);
    else if (pq_replace) dq <= q_rep(dq, pq_kvi);
    if (pq_deq || pq_replace) nstrobe <= nstrobe + 1;
  end

  assign pq_kvo   = dq[0];
  assign pq_empty = (dq[0].key == KEYINF);
  assign pq_full  = (dq[7].key != KEYINF);

  // Scoreboard and protocol monitor
  logic [34:0] sb[$];
  logic [34:0] exp_r;

  always @(negedge clk) begin
    if (!rst && cif.rsp_valid && cif.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(cif.rsp_valid), 64'(0));
      end else begin
        exp_r = sb.pop_front();
        chk("rsp", 64'({cif.rsp_kv, cif.rsp_empty, cif.rsp_full, cif.rsp_err}), 64'(exp_r));
      end
    end
    if (pq_deq || pq_replace) begin
      chk("strobe_while_busy", 64'(pq_busy), 64'(0));
      chk("strobe_dual", 64'(pq_deq && pq_replace), 64'(0));
      chk("strobe_in_rst", 64'(rst), 64'(0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic init_q(input qv_t v);
    dev_ld_v = v;
    dev_ld   = 1'b1;
    rq       = v;
    @(posedge clk); #1;
    dev_ld   = 1'b0;
  endtask

  task automatic start_cmd(input logic [1:0] op, input int key, input bit track);
    kv_t kv;
    kv = mk(key);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_kv    = kv;
    if (track) begin
      sb.push_back({rq[0], rq[0].key == KEYINF, rq[7].key != KEYINF, op == 2'b11});
      if (op == 2'b01)      rq = q_rep(rq, kv);
      else if (op == 2'b10) rq = q_deq(rq);
    end
  endtask

  task automatic wait_accept();
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = cif.cmd_ready;
      @(posedge clk); #1;
    end
    chk("accept_timeout", 64'(acc), 64'(1));
    cif.cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input int key, input bit track);
    start_cmd(op, key, track);
    wait_accept();
  endtask

  initial begin
    int ns;
    logic [CNT_W-1:0] s0;
    qv_t fq;

    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_kv    = '0;
    cif.rsp_ready = 1'b1;
    pq_busy       = 1'b0;

    // Reset
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cif.cmd_ready), 64'(0));
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(cif.rsp_valid), 64'(0));
    chk("rst_stat_ops", 64'(stat_ops), 64'(0));
    chk("rst_stat_stalls", 64'(stat_stalls), 64'(0));
    chk("rst_strobes", 64'({pq_replace, pq_deq}), 64'(0));
    chk("rst_cmd_ready_after", 64'(cif.cmd_ready), 64'(1));
    @(posedge clk); #1;

    // Back-to-back dequeues
    init_q(mkq3(3, 7, 9));
    send(2'b10, 0, 1);
    send(2'b10, 0, 1);
    send(2'b10, 0, 1);
    repeat (2) begin
      @(negedge clk);
      chk("b2b_rsp_valid", 64'(cif.rsp_valid), 64'(1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("b2b_rsp_idle", 64'(cif.rsp_valid), 64'(0));
    chk("b2b_stat_ops", 64'(stat_ops), 64'(3));
    @(posedge clk); #1;

    // Replace then peek
    init_q(mkq3(3, 7, 9));
    ns = nstrobe;
    send(2'b01, 5, 1);
    send(2'b00, 0, 1);
    cyc(3);
    chk("rep_peek_strobes", 64'(nstrobe - ns), 64'(1));

    // Busy stall
    init_q(mkq3(3, 7, 9));
    s0 = stat_stalls;
    pq_busy = 1'b1;
    send(2'b10, 0, 1);
    start_cmd(2'b10, 0, 1);
    repeat (4) begin
      @(negedge clk);
      chk("stall_cmd_ready", 64'(cif.cmd_ready), 64'(0));
      chk("stall_no_strobe", 64'(pq_deq), 64'(0));
      @(posedge clk); #1;
    end
    pq_busy = 1'b0;
    @(negedge clk);
    chk("stall_strobe", 64'(pq_deq), 64'(1));
    chk("stall_accept", 64'(cif.cmd_ready), 64'(1));
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    cyc(3);
    chk("stall_count", 64'(stat_stalls - s0), 64'(4));

    // Response backpressure
    init_q(mkq3(3, 7, 9));
    cif.rsp_ready = 1'b0;
    ns = nstrobe;
    send(2'b10, 0, 1);
    send(2'b10, 0, 1);
    start_cmd(2'b10, 0, 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_cmd_ready", 64'(cif.cmd_ready), 64'(0));
      @(posedge clk); #1;
    end
    chk("bp_one_strobe", 64'(nstrobe - ns), 64'(1));
    cif.rsp_ready = 1'b1;
    wait_accept();
    cyc(4);
    chk("bp_drained", 64'(sb.size()), 64'(0));

    // Illegal op
    init_q(mkq3(3, 7, 9));
    ns = nstrobe;
    send(2'b11, 0, 1);
    cyc(3);
    chk("ill_no_strobe", 64'(nstrobe - ns), 64'(0));

    // Dequeue on empty queue
    init_q(mkq3(16'hFFFF, 16'hFFFF, 16'hFFFF));
    send(2'b10, 0, 1);
    cyc(3);

    // Replace on full queue
    for (int i = 0; i < 8; i++) fq[i] = mk(10 * (i + 1));
    init_q(fq);
    send(2'b01, 15, 1);
    cyc(3);

    // Reset while a command is stalled on busy
    init_q(mkq3(3, 7, 9));
    ns = nstrobe;
    pq_busy = 1'b1;
    send(2'b10, 0, 0);
    cyc(2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd_ready", 64'(cif.cmd_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    pq_busy = 1'b0;
    cyc(5);
    chk("rst_mid_no_strobe", 64'(nstrobe - ns), 64'(0));
    chk("rst_mid_no_rsp", 64'(cif.rsp_valid), 64'(0));
    chk("rst_mid_stat_ops", 64'(stat_ops), 64'(0));

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
